// File: rtl/cpu_scoreboard.sv
// Register scoreboard: per-register count of in-flight writes, used to stall
// decode on RAW hazards and on write-after-write saturation.
module cpu_scoreboard #(
  parameter int NREGS   = 16,
  parameter int IDX_W   = 4,
  parameter int NREAD   = 2,
  parameter int MAXPEND = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  input  logic                   issue_we_i,
  input  logic [IDX_W-1:0]       issue_widx_i,
  input  logic [NREAD-1:0]       read_en_i,
  input  logic [NREAD*IDX_W-1:0] read_idx_i,
  input  logic                   wb_valid_i,
  input  logic [IDX_W-1:0]       wb_idx_i,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic [NREGS-1:0]       pending_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int              CNT_W   = $clog2(MAXPEND + 1);
  localparam logic [IDX_W:0]  NREGS_L = (IDX_W + 1)'(NREGS);
  localparam logic [CNT_W-1:0] SAT    = CNT_W'(MAXPEND);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic             err_q, err_d;

  logic             raw, rd_bad, wsat, stall, accept;
  logic             widx_ok, wb_ok, wb_zero;
  logic [IDX_W-1:0] ridx;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NREGS_L;
  endfunction

  // Hazard detection looks only at registered counts: no writeback bypass.
  always_comb begin
    raw    = 1'b0;
    rd_bad = 1'b0;
    ridx   = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      ridx = read_idx_i[p*IDX_W +: IDX_W];
      if (read_en_i[p]) begin
        if (!idx_ok(ridx))
          rd_bad = 1'b1;
        else if (cnt_q[ridx] != '0)
          raw = 1'b1;
      end
    end
    widx_ok = idx_ok(issue_widx_i);
    wb_ok   = idx_ok(wb_idx_i);
    wsat    = issue_we_i & widx_ok & (cnt_q[issue_widx_i] == SAT);
    stall   = issue_valid_i & (raw | wsat);
    accept  = issue_valid_i & ~stall & ~flush_i;
    wb_zero = wb_valid_i & wb_ok & (cnt_q[wb_idx_i] == '0);
  end

  always_comb begin
    err_d = err_q | wb_zero | (wb_valid_i & ~wb_ok)
          | (issue_valid_i & (rd_bad | (issue_we_i & ~widx_ok)));
    for (int unsigned r = 0; r < NREGS; r++) begin
      logic inc, dec;
      inc = accept & issue_we_i & widx_ok & (issue_widx_i == IDX_W'(r));
      dec = wb_valid_i & wb_ok & (wb_idx_i == IDX_W'(r)) & (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (flush_i)
        cnt_d[r] = '0;
      else if (inc && !dec)
        cnt_d[r] = cnt_q[r] + 1'b1;
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++)
      pending_o[r] = (cnt_q[r] != '0);
  end

  assign busy_o  = |pending_o;
  assign stall_o = stall;
  assign err_o   = err_q;

endmodule
